// File: rtl/voice_mixer.sv
// N-channel audio mixer: per-frame snapshot, per-channel gain/enable,
// time-multiplexed accumulation with one multiplier, ramped master level, saturation.
module voice_mixer #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned GW          = 8,
  parameter int unsigned MASTER_STEP = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_stb,
  input  logic [NCH*W-1:0]     ch_data,
  input  logic [NCH*GW-1:0]    ch_gain,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 play,
  output logic signed [W-1:0]  mix_out,
  output logic                 mix_valid,
  output logic                 clip,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW = W + GW + 1;                 // channel product width
  localparam int unsigned AW = W + GW + $clog2(NCH) + 1;   // accumulator width, never wraps
  localparam int unsigned SW = AW + GW + 2;                // acc * master product width

  // Master is kept one bit wider than GW so unity (2^(GW-1)) and the step sum both fit.
  localparam logic [GW:0] Unity = {2'b01, {(GW-1){1'b0}}};
  localparam logic [GW:0] Step  = (GW+1)'(MASTER_STEP);

  localparam logic signed [SW-1:0] SatHi = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SatLo = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StScale, StOut} state_e;

  state_e                state_q;
  logic signed [W-1:0]   data_q [NCH];
  logic [GW-1:0]         gain_q [NCH];
  logic [NCH-1:0]        en_q;
  logic [IW-1:0]         idx_q;
  logic signed [AW-1:0]  acc_q;
  logic [GW:0]           master_q;

  logic signed [PW-1:0]  prod_c;
  logic signed [AW-1:0]  term_c;
  logic signed [SW-1:0]  scaled_c;
  logic signed [W-1:0]   sat_c;
  logic                  sat_clip_c;
  logic [GW:0]           master_up_c;
  logic [GW:0]           master_next_c;

  // Datapath: current channel term, master scaling with saturation, next master level.
  always_comb begin
    prod_c   = data_q[idx_q] * $signed({1'b0, gain_q[idx_q]});
    term_c   = en_q[idx_q] ? AW'(prod_c >>> (GW-1)) : '0;
    scaled_c = (acc_q * $signed({1'b0, master_q})) >>> (GW-1);

    sat_clip_c = 1'b0;
    sat_c      = scaled_c[W-1:0];
    if (scaled_c > SatHi) begin
      sat_c      = SatHi[W-1:0];
      sat_clip_c = 1'b1;
    end else if (scaled_c < SatLo) begin
      sat_c      = SatLo[W-1:0];
      sat_clip_c = 1'b1;
    end

    master_up_c = master_q + Step;
    if (play) begin
      master_next_c = (master_up_c > Unity) ? Unity : master_up_c;
    end else begin
      master_next_c = (master_q < Step) ? '0 : master_q - Step;
    end
  end

  // Frame FSM with registered outputs; master only moves in OUT so SCALE sees the frame-start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
        gain_q[k] <= '0;
      end
      en_q      <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      master_q  <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_stb && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (sample_stb) begin
            for (int k = 0; k < NCH; k++) begin
              data_q[k] <= ch_data[k*W +: W];
              gain_q[k] <= ch_gain[k*GW +: GW];
            end
            en_q    <= ch_en;
            acc_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_q + term_c;
          if (idx_q == IW'(NCH-1)) begin
            state_q <= StScale;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StScale: begin
          mix_out   <= sat_c;
          clip      <= sat_clip_c;
          mix_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          master_q <= master_next_c;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: stimulus pushes model results, a monitor pops on mix_valid.
module tb_voice_mixer;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int GW  = 8;
  localparam int LAT = NCH + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_stb = 1'b0;
  logic [NCH*W-1:0]    ch_data = '0;
  logic [NCH*GW-1:0]   ch_gain = '0;
  logic [NCH-1:0]      ch_en = '0;
  logic                play = 1'b0;
  logic signed [W-1:0] mix_out;
  logic                mix_valid;
  logic                clip;
  logic                overrun;
  logic                busy;

  voice_mixer #(.NCH(NCH), .W(W), .GW(GW), .MASTER_STEP(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_stb (sample_stb),
    .ch_data    (ch_data),
    .ch_gain    (ch_gain),
    .ch_en      (ch_en),
    .play       (play),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .clip       (clip),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit clp;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference state: frame inputs and master level.
  int       d[NCH];
  int       g[NCH];
  bit [3:0] e;
  int       master = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every mix_valid must match the oldest outstanding frame, at the right latency.
  always @(negedge clk) begin
    if (!rst && mix_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: mix_out=%0d with no frame outstanding", mix_out);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (int'(mix_out) != x.val || clip != x.clp || (cyc - x.cyc) != LAT) begin
          failures++;
          $display("FAIL frame: got mix_out=%0d clip=%0d latency=%0d, expected %0d clip=%0d latency=%0d",
                   mix_out, clip, cyc - x.cyc, x.val, x.clp, LAT);
        end
      end
    end
  end

  // Model of one frame from the arithmetic rules; also advances master as OUT would.
  task automatic model_push();
    longint acc, sc;
    exp_t   x;
    acc = 0;
    for (int k = 0; k < NCH; k++)
      if (e[k]) acc += fdiv(longint'(d[k]) * g[k], 2 ** (GW - 1));
    sc = fdiv(acc * master, 2 ** (GW - 1));
    x.clp = 1'b0;
    x.val = int'(sc);
    if (sc > 32767)  begin x.val = 32767;  x.clp = 1'b1; end
    if (sc < -32768) begin x.val = -32768; x.clp = 1'b1; end
    x.cyc = cyc;
    exp_q.push_back(x);
    if (play) master = (master + 16 > 128) ? 128 : master + 16;
    else      master = (master < 16) ? 0 : master - 16;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NCH; k++) begin
      ch_data[k*W +: W]   = d[k][W-1:0];
      ch_gain[k*GW +: GW] = g[k][GW-1:0];
    end
    ch_en = e;
  endtask

  task automatic scramble_inputs();
    ch_data = {$urandom(), $urandom()};
    ch_gain = $urandom();
    ch_en   = 4'($urandom());
  endtask

  // Called at a negedge; issues one frame and returns at a negedge where a new frame may start.
  task automatic run_frame(input int gap);
    drive_inputs();
    sample_stb = 1'b1;
    model_push();
    @(negedge clk);
    sample_stb = 1'b0;
    scramble_inputs();
    repeat (gap) @(negedge clk);
  endtask

  task automatic set_single(input int v, input int gain, input bit en0);
    for (int k = 0; k < NCH; k++) begin
      d[k] = int'($urandom_range(0, 65535)) - 32768;
      g[k] = int'($urandom_range(0, 255));
    end
    d[0] = v;
    g[0] = gain;
    e    = {3'b000, en0};
  endtask

  task automatic set_random();
    for (int k = 0; k < NCH; k++) begin
      d[k] = int'($urandom_range(0, 65535)) - 32768;
      g[k] = int'($urandom_range(0, 255));
    end
    e = 4'($urandom());
  endtask

  int nvalid;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_mix_out", mix_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", mix_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp up from master 0, then hold at unity.
    play = 1'b1;
    set_single(1000, 128, 1'b1);
    drive_inputs();
    sample_stb = 1'b1;
    model_push();
    @(negedge clk);
    sample_stb = 1'b0;
    chk("busy_in_frame", busy, 1);
    repeat (6) @(negedge clk);
    chk("busy_after_frame", busy, 0);
    for (int i = 0; i < 11; i++) run_frame(6 + int'($urandom_range(0, 2)));

    // Ramp down to 0 and hold.
    play = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_single(1000, 128, 1'b1);
      run_frame(6 + int'($urandom_range(0, 2)));
    end

    // Back to unity, then saturation both ways.
    play = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_single(1000, 128, 1'b1);
      run_frame(6);
    end
    for (int k = 0; k < NCH; k++) begin d[k] = 16000; g[k] = 255; end
    e = 4'b1111;
    run_frame(6);
    for (int k = 0; k < NCH; k++) d[k] = -16000;
    run_frame(6);

    // Reset in the middle of ACCUM aborts the frame and clears everything.
    set_random();
    drive_inputs();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mix_out", mix_out, 0);
    chk("midrst_clip", clip, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", mix_valid, 0);
    chk("midrst_overrun", overrun, 0);
    master = 0;
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mix_valid) nvalid++;
    end
    chk("midrst_no_valid", nvalid, 0);

    // Ramp back up using random mixes, then half-gain floor cases.
    for (int i = 0; i < 9; i++) begin
      set_random();
      run_frame(6);
    end
    set_single(1000, 64, 1'b1);  run_frame(6);
    set_single(-1000, 64, 1'b1); run_frame(6);
    set_single(3, 64, 1'b1);     run_frame(6);
    set_single(-3, 64, 1'b1);    run_frame(6);
    set_single(1000, 64, 1'b0);  run_frame(6);

    // Overrun: stb 3 cycles after frame start, then one in the OUT cycle.
    set_single(1234, 200, 1'b1);
    drive_inputs();
    sample_stb = 1'b1;
    model_push();
    @(negedge clk);
    sample_stb = 1'b0;
    scramble_inputs();
    @(negedge clk);
    @(negedge clk);
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("overrun_pulse", overrun, 1);
    @(negedge clk);
    chk("overrun_clears", overrun, 0);
    @(negedge clk);
    sample_stb = 1'b1;  // OUT cycle of the running frame
    @(negedge clk);
    sample_stb = 1'b0;
    chk("overrun_in_out", overrun, 1);
    chk("idle_after_out", busy, 0);
    repeat (3) @(negedge clk);

    // Random traffic with play toggling.
    for (int i = 0; i < 40; i++) begin
      play = ($urandom_range(0, 3) != 0);
      set_random();
      run_frame(6 + int'($urandom_range(0, 3)));
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
